ps2kb_xt_irq_buffer: RTL and testbench

Byte buffer and XT-style interrupt handshake stage between the PS/2 keyboard byte decoder and the Tandy scancode converter. Queues XT (set 1) scancode bytes, including E0 prefixes, in a small FIFO. Presents them one at a time on `scancode` with `keybord_irq` high until the CPU clears the keycode through the PPI. Guarantees the downstream stage sees a clean irq rising edge and falling edge per byte, with `scancode` stable around both edges.

---
 rtl/ps2kb_xt_irq_buffer.sv | 177 +++++++++++++++++
 tb/tb_ps2kb_xt_irq_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2kb_xt_irq_buffer.sv
// Queues XT scancode bytes and presents them one at a time with an XT-style irq handshake.
// Latency: 3 cycles from in_valid into an idle, empty buffer to scancode/keybord_irq.
// Backpressure: none upstream; a full FIFO drops bytes, sets overflow and later queues 8'hFF.
module ps2kb_xt_irq_buffer #(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int IRQ_GAP_CYCLES  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     clear_keycode,
    input  logic                     flush,
    output logic [7:0]               scancode,
    output logic                     keybord_irq,
    output logic                     overflow,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [7:0] GAP_LOAD = 8'(IRQ_GAP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESENT,
        ST_ACK,
        ST_GAP
    } state_t;

    state_t                       state_q, state_d;
    logic [7:0]                   gap_q, gap_d;
    logic [7:0]                   scancode_q, scancode_d;
    logic                         irq_q, irq_d;
    logic                         overflow_q, overflow_d;
    logic                         overrun_q, overrun_d;
    logic [FIFO_DEPTH_LOG2-1:0]   head_q, head_d;
    logic [FIFO_DEPTH_LOG2-1:0]   tail_q, tail_d;
    logic [FIFO_DEPTH_LOG2:0]     count_q, count_d;
    logic [7:0]                   mem_q [DEPTH];

    logic                         wr_en;
    logic [7:0]                   wr_dat;
    logic                         pop;

    // FIFO bookkeeping: push, overrun marker insertion, pop on LOAD, flush clear
    always_comb begin
        wr_en      = 1'b0;
        wr_dat     = in_data;
        pop        = (state_q == ST_LOAD);
        overrun_d  = overrun_q;
        overflow_d = overflow_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overrun_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (overrun_q) begin
                // Everything arriving while the marker is owed is lost.
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                // The marker waits for a cycle with room and no pop so the count stays exact.
                if (count_q != DEPTH_CNT && !pop) begin
                    wr_en     = 1'b1;
                    wr_dat    = 8'hFF;
                    overrun_d = 1'b0;
                end
            end else if (in_valid) begin
                // Fullness is judged on the pre-cycle count; a same-cycle pop does not help.
                if (count_q == DEPTH_CNT) begin
                    overflow_d = 1'b1;
                    overrun_d  = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
            end
            if (wr_en) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Handshake sequencing: load a byte, hold irq until acknowledged, then enforce the low gap
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        scancode_d = scancode_q;
        if (flush) begin
            state_d    = ST_GAP;
            gap_d      = GAP_LOAD;
            scancode_d = 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    scancode_d = mem_q[head_q];
                    state_d    = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (clear_keycode) begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!clear_keycode) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q <= 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // irq is registered so it rises together with the freshly loaded scancode.
        irq_d = (state_d == ST_PRESENT);
    end

    // State and control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gap_q      <= 8'h00;
            scancode_q <= 8'h00;
            irq_q      <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            scancode_q <= scancode_d;
            irq_q      <= irq_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Byte storage; contents are only meaningful below count, so no reset is needed
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[tail_q] <= wr_dat;
        end
    end

    assign scancode    = scancode_q;
    assign keybord_irq = irq_q;
    assign overflow    = overflow_q;
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_ps2kb_xt_irq_buffer.sv
// Directed bench for ps2kb_xt_irq_buffer with a cycle-level reference model.
// Model runs on the rising edge, DUT outputs are compared on the falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_ps2kb_xt_irq_buffer;
    localparam int LOG2 = 3;
    localparam int D    = 8;
    localparam int G    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        clear_keycode = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  scancode;
    logic        keybord_irq;
    logic        overflow;
    logic [LOG2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ps2kb_xt_irq_buffer #(.FIFO_DEPTH_LOG2(LOG2), .IRQ_GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .clear_keycode(clear_keycode), .flush(flush), .scancode(scancode),
        .keybord_irq(keybord_irq), .overflow(overflow), .fifo_count(fifo_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus timestamps for when the presenter may take the next byte.
    logic [7:0] mq[$];
    logic [7:0] m_sc = 8'h00;
    logic       m_irq = 1'b0, m_ovf = 1'b0, m_pend = 1'b0, m_busy = 1'b0, m_acked = 1'b0;
    int         m_cyc = 0, m_free_at = 0, m_load_at = -1;

    always @(posedge clock) begin : model
        int   cnt;
        logic pop;
        logic n_irq;
        if (reset) begin
            mq.delete();
            m_sc = 8'h00; m_irq = 1'b0; m_ovf = 1'b0; m_pend = 1'b0;
            m_busy = 1'b0; m_acked = 1'b0; m_cyc = 0; m_free_at = 0; m_load_at = -1;
        end else begin
            if (flush) begin
                mq.delete();
                m_sc = 8'h00; m_irq = 1'b0; m_ovf = 1'b0; m_pend = 1'b0;
                m_busy = 1'b0; m_acked = 1'b0; m_load_at = -1;
                m_free_at = m_cyc + G + 1;
            end else begin
                cnt = mq.size();
                pop = (m_load_at == m_cyc);
                if (pop) m_load_at = -1;
                n_irq = m_irq;
                if (m_irq && clear_keycode) begin
                    n_irq = 1'b0;
                    m_acked = 1'b1;
                end else if (m_acked && !clear_keycode) begin
                    m_acked = 1'b0;
                    m_busy = 1'b0;
                    m_free_at = m_cyc + G + 1;
                end
                if (pop) begin
                    m_sc = mq.pop_front();
                    n_irq = 1'b1;
                end
                if (m_pend) begin
                    if (in_valid) m_ovf = 1'b1;
                    if (cnt < D && !pop) begin
                        mq.push_back(8'hFF);
                        m_pend = 1'b0;
                    end
                end else if (in_valid) begin
                    if (cnt == D) begin
                        m_ovf = 1'b1;
                        m_pend = 1'b1;
                    end else begin
                        mq.push_back(in_data);
                    end
                end
                if (!m_busy && m_cyc >= m_free_at && cnt > 0) begin
                    m_busy = 1'b1;
                    m_load_at = m_cyc + 1;
                end
                m_irq = n_irq;
            end
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, plus scancode stability while irq is high
    logic       prev_irq = 1'b0;
    logic [7:0] prev_sc = 8'h00;
    always @(negedge clock) begin
        if (!reset) begin
            check("model_scancode", scancode, m_sc);
            check("model_irq", keybord_irq, m_irq);
            check("model_overflow", overflow, m_ovf);
            check("model_count", fifo_count, mq.size());
            if (keybord_irq && prev_irq) check("sc_stable_irq_high", scancode, prev_sc);
            prev_irq = keybord_irq;
            prev_sc = scancode;
        end else begin
            prev_irq = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        in_data = b;
        in_valid = 1'b1;
        step();
    endtask

    task automatic wait_irq();
        int n = 0;
        while (keybord_irq !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("wait_irq_high", keybord_irq, 1'b1);
    endtask

    // Counts cycles irq stays low, starting at the current cycle.
    task automatic count_low(output int low);
        low = 0;
        while (keybord_irq !== 1'b1 && low < 200) begin
            low++;
            step();
        end
    endtask

    task automatic ack_last();
        clear_keycode = 1'b1;
        step();
        clear_keycode = 1'b0;
        repeat (G + 6) step();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int low;
        int peak;
        logic [7:0] exp_b;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_scancode", scancode, 8'h00);
        check("reset_irq", keybord_irq, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_count", fifo_count, 0);
        repeat (2) step();

        // Single byte: 3-cycle latency, ack drops irq next cycle
        push(8'h1E);
        check("single_count_c1", fifo_count, 1);
        check("single_irq_c1", keybord_irq, 1'b0);
        step();
        check("single_irq_c2", keybord_irq, 1'b0);
        step();
        check("single_irq_c3", keybord_irq, 1'b1);
        check("single_sc_c3", scancode, 8'h1E);
        check("single_count_c3", fifo_count, 0);
        clear_keycode = 1'b1;
        step();
        check("single_irq_after_ack", keybord_irq, 1'b0);
        clear_keycode = 1'b0;
        repeat (G + 6) step();

        // E0 prefix sequence: two pulses, gap of G+3 low cycles
        push(8'hE0);
        push(8'h48);
        wait_irq();
        check("prefix_first", scancode, 8'hE0);
        clear_keycode = 1'b1;
        step();
        clear_keycode = 1'b0;
        count_low(low);
        check("prefix_gap", low, G + 3);
        check("prefix_second", scancode, 8'h48);
        ack_last();

        // Held acknowledge with three bytes queued
        push(8'h1C);
        push(8'h32);
        push(8'h21);
        check("held_first_sc", scancode, 8'h1C);
        check("held_first_irq", keybord_irq, 1'b1);
        clear_keycode = 1'b1;
        repeat (10) step();
        check("held_irq_low", keybord_irq, 1'b0);
        check("held_count", fifo_count, 2);
        clear_keycode = 1'b0;
        count_low(low);
        check("held_release_latency", low, G + 3);
        check("held_second_sc", scancode, 8'h32);
        clear_keycode = 1'b1;
        step();
        clear_keycode = 1'b0;
        wait_irq();
        check("held_third_sc", scancode, 8'h21);
        ack_last();

        // Overflow: ten bytes with no acknowledge, then one more while overrun pending
        peak = 0;
        for (int i = 1; i <= 10; i++) begin
            push(8'(i));
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        push(8'h0B);
        check("ovf_peak", peak, D);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_first_sc", scancode, 8'h01);
        for (int k = 0; k < 10; k++) begin
            exp_b = (k == 9) ? 8'hFF : 8'(k + 1);
            wait_irq();
            check("ovf_order", scancode, exp_b);
            clear_keycode = 1'b1;
            step();
            clear_keycode = 1'b0;
            step();
        end
        repeat (20) step();
        check("ovf_drained_irq", keybord_irq, 1'b0);
        check("ovf_drained_count", fifo_count, 0);
        check("ovf_sticky", overflow, 1'b1);

        // Flush mid-PRESENT with four bytes queued and a same-cycle push
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        check("flush_pre_count", fifo_count, 4);
        check("flush_pre_irq", keybord_irq, 1'b1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        step();
        check("flush_irq", keybord_irq, 1'b0);
        check("flush_sc", scancode, 8'h00);
        check("flush_count", fifo_count, 0);
        check("flush_overflow", overflow, 1'b0);
        repeat (20) step();
        check("flush_quiet_irq", keybord_irq, 1'b0);
        push(8'h2A);
        step();
        step();
        check("flush_new_irq", keybord_irq, 1'b1);
        check("flush_new_sc", scancode, 8'h2A);
        ack_last();

        // Asynchronous reset while irq is high
        push(8'h3C);
        push(8'h44);
        step();
        check("rst_pre_irq", keybord_irq, 1'b1);
        check("rst_pre_sc", scancode, 8'h3C);
        #2 reset = 1'b1;
        #1;
        check("rst_async_irq", keybord_irq, 1'b0);
        check("rst_async_sc", scancode, 8'h00);
        check("rst_async_count", fifo_count, 0);
        check("rst_async_overflow", overflow, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (8) step();
        check("rst_after_irq", keybord_irq, 1'b0);
        check("rst_after_count", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
